// File: rtl/sha256_job_ctrl.sv
// Byte-stream to SHA256-core sequencer: packs bytes into words, starts the core, latches the digest.
// Optional WAIT watchdog is compiled in with `define SHA256_JOB_TIMEOUT_EN.
module sha256_job_ctrl #(
   parameter int MAX_BYTES      = 4096,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         s_valid,
   input  logic [7:0]   s_data,
   input  logic         s_last,
   output logic         s_ready,
   output logic         res_valid,
   output logic [255:0] res_digest,
   output logic         res_error,
   input  logic         res_ack,
   output logic [31:0]  core_in_data,
   output logic [7:0]   core_in_len,
   output logic         core_write,
   output logic         core_start,
   output logic         core_reset,
   input  logic [255:0] core_digest,
   input  logic         core_ready,
   output logic [2:0]   state_dbg
);

   // Requester handshake: a byte moves when s_valid & s_ready on a rising clk; s_data/s_last
   // must be stable while s_valid is high. Result handshake: res_valid holds until res_valid & res_ack.
   localparam int CW = $clog2(MAX_BYTES + 1);

   localparam logic [2:0] ST_INIT   = 3'd0;
   localparam logic [2:0] ST_IDLE   = 3'd1;
   localparam logic [2:0] ST_LOAD   = 3'd2;
   localparam logic [2:0] ST_START  = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_CLEAR  = 3'd5;
   localparam logic [2:0] ST_RESULT = 3'd6;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic          err;
   logic [31:0]   word;
   logic [31:0]   word_nxt;
   logic [1:0]    lane;
   logic [2:0]    lane_p1;
   logic          accept;
   logic          at_max;

   assign s_ready    = (state == ST_IDLE) || (state == ST_LOAD);
   assign res_valid  = (state == ST_RESULT);
   assign core_reset = (state == ST_INIT) || (state == ST_CLEAR);
   assign state_dbg  = state;

   assign accept  = s_valid & s_ready;
   assign lane    = cnt[1:0];
   assign lane_p1 = {1'b0, lane} + 3'd1;
   assign at_max  = (cnt == CW'(MAX_BYTES));

   always_comb begin
      word_nxt = word;
      word_nxt[{lane, 3'b000} +: 8] = s_data;
   end

`ifdef SHA256_JOB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo;
`else
   logic unused_cfg;
   assign unused_cfg = TIMEOUT_CYCLES[0];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_INIT;
         cnt          <= '0;
         err          <= 1'b0;
         word         <= '0;
         res_digest   <= '0;
         res_error    <= 1'b0;
         core_in_data <= '0;
         core_in_len  <= '0;
         core_write   <= 1'b0;
         core_start   <= 1'b0;
`ifdef SHA256_JOB_TIMEOUT_EN
         tmo          <= '0;
`endif
      end else begin
         core_write <= 1'b0;
         core_start <= 1'b0;
         case (state)
            ST_INIT: begin
               // cnt doubles as the core-reset cycle counter before the first job
               if (cnt == CW'(1)) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_IDLE, ST_LOAD: begin
               if (accept) begin
                  state <= ST_LOAD;
                  if (at_max || err) begin
                     err <= 1'b1;
                     if (s_last) begin
                        res_digest <= '0;
                        res_error  <= 1'b1;
                        state      <= ST_CLEAR;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                     if (lane == 2'd3 || s_last) begin
                        core_write   <= 1'b1;
                        core_in_data <= word_nxt;
                        core_in_len  <= {2'b00, lane_p1, 3'b000};
                        word         <= '0;
                     end else begin
                        word <= word_nxt;
                     end
                     if (s_last) state <= ST_START;
                  end
               end
            end
            ST_START: begin
               // final write is on the wire this cycle; start follows on the next
               core_start <= 1'b1;
               state      <= ST_WAIT;
`ifdef SHA256_JOB_TIMEOUT_EN
               tmo        <= '0;
`endif
            end
            ST_WAIT: begin
               if (core_ready) begin
                  res_digest <= core_digest;
                  res_error  <= 1'b0;
                  state      <= ST_CLEAR;
               end
`ifdef SHA256_JOB_TIMEOUT_EN
               else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                  res_digest <= '0;
                  res_error  <= 1'b1;
                  state      <= ST_CLEAR;
               end else begin
                  tmo <= tmo + 1'b1;
               end
`endif
            end
            ST_CLEAR: state <= ST_RESULT;
            ST_RESULT: begin
               if (res_ack) begin
                  cnt   <= '0;
                  err   <= 1'b0;
                  word  <= '0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_job_ctrl.sv
// Bench for sha256_job_ctrl: drives byte jobs against a behavioural SHA256 core and scores
// core writes and results from queues filled when each job is driven.
module tb_sha256_job_ctrl;

   localparam int MAXB = 64;
   localparam int TMO  = 200;
   localparam logic [255:0] ABC_DIG =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   // clock / reset
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   always #5 clk = ~clk;

   logic         s_valid = 1'b0;
   logic [7:0]   s_data = '0;
   logic         s_last = 1'b0;
   logic         res_ack = 1'b0;
   logic         core_ready = 1'b0;
   logic [255:0] core_digest = '0;
   logic         s_ready, res_valid, res_error, core_write, core_start, core_reset;
   logic [255:0] res_digest;
   logic [31:0]  core_in_data;
   logic [7:0]   core_in_len;
   logic [2:0]   state_dbg;

   sha256_job_ctrl #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .res_valid(res_valid), .res_digest(res_digest), .res_error(res_error), .res_ack(res_ack),
      .core_in_data(core_in_data), .core_in_len(core_in_len), .core_write(core_write),
      .core_start(core_start), .core_reset(core_reset),
      .core_digest(core_digest), .core_ready(core_ready), .state_dbg(state_dbg));

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard queues
   logic [39:0]  exp_wr_q[$];
   logic [255:0] exp_dig_q[$];
   logic         exp_err_q[$];
   logic [7:0]   msg_q[$];
   logic [7:0]   core_buf[$];

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha256(input logic [7:0] m[$]);
      logic [7:0]  p[$];
      logic [31:0] hv[8];
      logic [31:0] w[64];
      logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, s0, s1, t1, t2;
      longint unsigned bl;
      p = m;
      bl = longint'(m.size()) * 8;
      hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(8'(bl >> (8 * i)));
      for (int blk = 0; blk < p.size() / 64; blk++) begin
         for (int t = 0; t < 16; t++)
            w[t] = {p[blk*64+4*t], p[blk*64+4*t+1], p[blk*64+4*t+2], p[blk*64+4*t+3]};
         for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
         end
         va = hv[0]; vb = hv[1]; vc = hv[2]; vd = hv[3];
         ve = hv[4]; vf = hv[5]; vg = hv[6]; vh = hv[7];
         for (int t = 0; t < 64; t++) begin
            s1 = rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25);
            t1 = vh + s1 + ((ve & vf) ^ (~ve & vg)) + K_TAB[t] + w[t];
            s0 = rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22);
            t2 = s0 + ((va & vb) ^ (va & vc) ^ (vb & vc));
            vh = vg; vg = vf; vf = ve; ve = vd + t1;
            vd = vc; vc = vb; vb = va; va = t1 + t2;
         end
         hv[0] += va; hv[1] += vb; hv[2] += vc; hv[3] += vd;
         hv[4] += ve; hv[5] += vf; hv[6] += vg; hv[7] += vh;
      end
      return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
   endfunction

   // behavioural core: collects written bytes, answers a start after core_lat cycles
   int   core_lat = 5;
   logic core_hold = 1'b0;
   int   core_cnt = -1;
   int   rdy_cyc = 0;
   always @(negedge clk) begin
      if (!reset_n || core_reset) begin
         core_ready  <= 1'b0;
         core_digest <= '0;
         core_buf.delete();
         core_cnt    <= -1;
      end else begin
         if (core_write)
            for (int i = 0; i < 4 && i < int'(core_in_len) / 8; i++) core_buf.push_back(core_in_data[8*i +: 8]);
         if (core_start) core_cnt <= core_lat;
         else if (core_cnt > 0) core_cnt <= core_cnt - 1;
         else if (core_cnt == 0 && !core_hold) begin
            core_ready  <= 1'b1;
            core_digest <= sha256(core_buf);
            core_cnt    <= -1;
            rdy_cyc     <= cyc;
         end
      end
   end

   // monitor: pops the scoreboard on every write and on each new result
   int          n_wr = 0, n_start = 0, n_crst = 0, last_wr = 0;
   logic        res_seen = 1'b0;
   logic [39:0] mon_e;
   logic [255:0] mon_d;
   logic        mon_x;
   always @(negedge clk) begin
      if (reset_n) begin
         if (core_write) begin
            n_wr <= n_wr + 1;
            last_wr <= cyc;
            check_val("wr_no_start", core_start, 1'b0);
            if (exp_wr_q.size() == 0) check_val("wr_extra", core_write, 1'b0);
            else begin
               mon_e = exp_wr_q.pop_front();
               check_val("wr_data", core_in_data, mon_e[31:0]);
               check_val("wr_len", core_in_len, mon_e[39:32]);
            end
         end
         if (core_start) begin
            n_start <= n_start + 1;
            check_val("start_lat", cyc - last_wr, 1);
         end
         if (res_valid && !res_seen) begin
            if (exp_dig_q.size() == 0) check_val("res_extra", res_valid, 1'b0);
            else begin
               mon_d = exp_dig_q.pop_front();
               mon_x = exp_err_q.pop_front();
               check_val("res_digest", res_digest, mon_d);
               check_val("res_error", res_error, mon_x);
               if (!mon_x) check_val("res_lat", cyc - rdy_cyc, 2);
            end
         end
         if (core_reset) n_crst <= n_crst + 1;
      end
      res_seen <= res_valid;
   end

   // driver tasks
   task automatic do_reset();
      int c;
      @(negedge clk);
      reset_n = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      res_ack = 1'b0;
      #1;
      check_val("rst_s_ready", s_ready, 1'b0);
      check_val("rst_res_valid", res_valid, 1'b0);
      check_val("rst_res_digest", res_digest, '0);
      check_val("rst_res_error", res_error, 1'b0);
      check_val("rst_core_write", core_write, 1'b0);
      check_val("rst_core_start", core_start, 1'b0);
      check_val("rst_core_data", core_in_data, '0);
      check_val("rst_core_len", core_in_len, '0);
      check_val("rst_core_reset", core_reset, 1'b1);
      exp_wr_q.delete();
      exp_dig_q.delete();
      exp_err_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      c = int'(core_reset);
      repeat (3) begin
         @(negedge clk);
         c += int'(core_reset);
      end
      check_val("init_cycles", c, 2);
      check_val("init_ready", s_ready, 1'b1);
   endtask

   task automatic send_msg(input bit gaps, input bit exp_fail);
      logic [31:0] w;
      int lane, n, k;
      n = msg_q.size();
      w = '0;
      lane = 0;
      for (int i = 0; i < n && i < MAXB; i++) begin
         w[8*lane +: 8] = msg_q[i];
         lane++;
         if (lane == 4 || i == n - 1) begin
            exp_wr_q.push_back({8'(lane * 8), w});
            w = '0;
            lane = 0;
         end
      end
      if (n > MAXB || exp_fail) begin
         exp_dig_q.push_back('0);
         exp_err_q.push_back(1'b1);
      end else begin
         exp_dig_q.push_back(sha256(msg_q));
         exp_err_q.push_back(1'b0);
      end
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = msg_q[i];
         s_last  = (i == n - 1);
         k = 0;
         while (!s_ready && k < 50) begin
            @(negedge clk);
            k++;
         end
         if (k == 50) check_val("byte_wait", s_ready, 1'b1);
         @(posedge clk);
         #1;
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   task automatic wait_result(input int budget);
      int k;
      k = 0;
      while (!res_valid && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_val("res_wait", res_valid, 1'b1);
   endtask

   task automatic ack_result();
      res_ack = 1'b1;
      @(negedge clk);
      res_ack = 1'b0;
      check_val("ack_valid", res_valid, 1'b0);
      check_val("ack_ready", s_ready, 1'b1);
   endtask

   task automatic load_abc();
      msg_q.delete();
      msg_q.push_back(8'h61);
      msg_q.push_back(8'h62);
      msg_q.push_back(8'h63);
   endtask

   int s0, w0, r0;
   task automatic snap();
      s0 = n_start;
      w0 = n_wr;
      r0 = n_crst;
   endtask

   task automatic check_counts(input int ds, input int dw);
      check_val("n_start", n_start - s0, ds);
      check_val("n_write", n_wr - w0, dw);
      check_val("n_clear", n_crst - r0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // stray ack in IDLE has no effect
      res_ack = 1'b1;
      @(negedge clk);
      res_ack = 1'b0;
      @(negedge clk);
      check_val("stray_ack_ready", s_ready, 1'b1);
      check_val("stray_ack_valid", res_valid, 1'b0);

      // "abc", with s_valid asserted while the job is in flight, then result held 20 cycles
      snap();
      load_abc();
      send_msg(1'b0, 1'b0);
      s_valid = 1'b1;
      s_data  = 8'hff;
      s_last  = 1'b1;
      repeat (3) @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      wait_result(100);
      repeat (20) begin
         @(negedge clk);
         check_val("hold_valid", res_valid, 1'b1);
         check_val("hold_digest", res_digest, ABC_DIG);
         check_val("hold_ready", s_ready, 1'b0);
      end
      check_counts(1, 1);
      ack_result();

      // "abcd": one full word
      snap();
      msg_q.delete();
      for (int i = 0; i < 4; i++) msg_q.push_back(8'(8'h61 + i));
      send_msg(1'b0, 1'b0);
      wait_result(100);
      check_counts(1, 1);
      ack_result();

      // 56 random bytes with gaps
      snap();
      core_lat = $urandom_range(1, 12);
      msg_q.delete();
      for (int i = 0; i < 56; i++) msg_q.push_back(8'($urandom_range(0, 255)));
      send_msg(1'b1, 1'b0);
      wait_result(100);
      check_counts(1, 14);
      ack_result();

      // overflow: MAXB+3 bytes
      snap();
      msg_q.delete();
      for (int i = 0; i < MAXB + 3; i++) msg_q.push_back(8'($urandom_range(0, 255)));
      send_msg(1'b0, 1'b0);
      wait_result(100);
      check_counts(0, MAXB / 4);
      ack_result();

      // second "abc" job after the error
      core_lat = 3;
      load_abc();
      send_msg(1'b1, 1'b0);
      wait_result(100);
      check_val("abc2_digest", res_digest, ABC_DIG);
      ack_result();

      // reset while waiting on the core
      core_hold = 1'b1;
      load_abc();
      send_msg(1'b0, 1'b0);
      repeat (10) @(negedge clk);
      check_val("midwait_valid", res_valid, 1'b0);
      do_reset();
      core_hold = 1'b0;

`ifdef SHA256_JOB_TIMEOUT_EN
      core_hold = 1'b1;
      load_abc();
      send_msg(1'b0, 1'b1);
      wait_result(TMO + 50);
      ack_result();
      core_hold = 1'b0;
`endif

      load_abc();
      send_msg(1'b0, 1'b0);
      wait_result(100);
      check_val("post_rst_digest", res_digest, ABC_DIG);
      ack_result();

      repeat (3) @(negedge clk);
      check_val("wr_q_empty", exp_wr_q.size(), 0);
      check_val("res_q_empty", exp_dig_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
